// File: rtl/spatz_simd_lane_pipe.sv
// Spatz integer SIMD lane with an elastic valid/ready output pipeline.
//
// The Width-bit datapath is split into Width/SEW independent elements. SEW is
// chosen per request by sew_i. All arithmetic is combinational ahead of stage
// 0. The result then moves through NumPipeRegs bubble-collapsing register
// stages, carrying the request tag with it.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   operation_i, sew_i        operation and element width
//   op_s1_i/op_s2_i/op_d_i    packed operands (d = destination/accumulator)
//   is_signed_i               signed compare / multiply-high interpretation
//   tag_i, in_valid_i         request tag and valid; in_ready_o = accept
//   result_o, tag_o           result and its tag, qualified by out_valid_o
//   out_ready_i               consumer accepts the result
//   busy_o                    any pipeline stage holds an entry

package rvv_pkg;
  typedef enum logic [1:0] {EW_8 = 2'd0, EW_16 = 2'd1, EW_32 = 2'd2, EW_64 = 2'd3} vew_e;
endpackage

package spatz_pkg;
  typedef enum logic [4:0] {
    VADD, VSUB, VRSUB, VAND, VOR, VXOR,
    VMIN, VMINU, VMAX, VMAXU,
    VSLL, VSRL, VSRA,
    VMUL, VMULH, VMULHU, VMULHSU,
    VMACC, VNMSAC, VMADD, VNMSUB,
    VNOP
  } op_e;
endpackage

// One SEW-bit element. The lane instantiates an array of these per SEW.
module spatz_simd_elem #(
  parameter int SEW = 8
) (
  input  spatz_pkg::op_e   op,
  input  logic [SEW-1:0]   s1,
  input  logic [SEW-1:0]   s2,
  input  logic [SEW-1:0]   d,
  input  logic             is_signed,
  output logic [SEW-1:0]   res
);
  import spatz_pkg::*;
  localparam int SHW = $clog2(SEW);

  logic [SEW-1:0]   mul_b;
  logic             s1_sx, s2_sx;
  logic [2*SEW-1:0] mul_a_x, mul_b_x, prod;
  logic [SEW-1:0]   prod_lo, prod_hi;
  logic             s2_lt_s1;
  logic [SHW-1:0]   shamt;

  // One 2*SEW multiplier covers every product. The operands are extended to
  // 2*SEW bits, signed or unsigned, so the low 2*SEW bits of the truncated
  // product give the correct high half for every multiply-high variant.
  always_comb begin
    mul_b   = (op == VMADD || op == VNMSUB) ? d : s2;
    s1_sx   = is_signed & (op == VMULH || op == VMULHSU) & s1[SEW-1];
    s2_sx   = is_signed & (op == VMULH) & mul_b[SEW-1];
    mul_a_x = {{SEW{s1_sx}}, s1};
    mul_b_x = {{SEW{s2_sx}}, mul_b};
  end

  assign prod     = mul_a_x * mul_b_x;
  assign prod_lo  = prod[SEW-1:0];
  assign prod_hi  = prod[2*SEW-1:SEW];
  assign s2_lt_s1 = is_signed ? ($signed(s2) < $signed(s1)) : (s2 < s1);
  assign shamt    = s2[SHW-1:0];

  always_comb begin
    res = '0;
    unique case (op)
      VADD:                       res = s2 + s1;
      VSUB:                       res = s2 - s1;
      VRSUB:                      res = s1 - s2;
      VAND:                       res = s1 & s2;
      VOR:                        res = s1 | s2;
      VXOR:                       res = s1 ^ s2;
      // On a tie, MIN keeps s1 and MAX keeps s2.
      VMIN, VMINU:                res = s2_lt_s1 ? s2 : s1;
      VMAX, VMAXU:                res = s2_lt_s1 ? s1 : s2;
      VSLL:                       res = s1 << shamt;
      VSRL:                       res = s1 >> shamt;
      VSRA:                       res = SEW'($signed(s1) >>> shamt);
      VMUL:                       res = prod_lo;
      VMULH, VMULHU, VMULHSU:     res = prod_hi;
      VMACC:                      res = d + prod_lo;
      VNMSAC:                     res = d - prod_lo;
      VMADD:                      res = s2 + prod_lo;
      VNMSUB:                     res = s2 - prod_lo;
      default:                    res = '0;
    endcase
  end
endmodule

module spatz_simd_lane_pipe #(
  parameter int Width       = 64,
  parameter int NumPipeRegs = 2,
  parameter int TagWidth    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  spatz_pkg::op_e       operation_i,
  input  logic [Width-1:0]     op_s1_i,
  input  logic [Width-1:0]     op_s2_i,
  input  logic [Width-1:0]     op_d_i,
  input  logic                 is_signed_i,
  input  rvv_pkg::vew_e        sew_i,
  input  logic [TagWidth-1:0]  tag_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [Width-1:0]     result_o,
  output logic [TagWidth-1:0]  tag_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o
);
  import rvv_pkg::*;

  typedef struct packed {
    logic [Width-1:0]    result;
    logic [TagWidth-1:0] tag;
  } payload_t;

  // ---------------- combinational datapath ----------------
  // One element array per SEW. An SEW wider than the datapath yields zero.
  logic [Width-1:0] res_sew [4];
  logic [Width-1:0] res_comb;

  for (genvar g = 0; g < 4; g++) begin : g_sew
    localparam int SEW = 8 << g;
    if (SEW <= Width) begin : g_on
      for (genvar e = 0; e < Width / SEW; e++) begin : g_elem
        spatz_simd_elem #(.SEW(SEW)) u_elem (
          .op        (operation_i),
          .s1        (op_s1_i[e*SEW +: SEW]),
          .s2        (op_s2_i[e*SEW +: SEW]),
          .d         (op_d_i[e*SEW +: SEW]),
          .is_signed (is_signed_i),
          .res       (res_sew[g][e*SEW +: SEW])
        );
      end
    end else begin : g_off
      assign res_sew[g] = '0;
    end
  end

  always_comb begin
    res_comb = '0;
    unique case (sew_i)
      EW_8:    res_comb = res_sew[0];
      EW_16:   res_comb = res_sew[1];
      EW_32:   res_comb = res_sew[2];
      EW_64:   res_comb = res_sew[3];
      default: res_comb = '0;
    endcase
  end

  // ---------------- elastic pipeline ----------------
  // Index 0 is the request side. Index k+1 is register stage k.
  // rdy[k] is the ready of stage k, and rdy[NumPipeRegs] is the consumer.
  logic [NumPipeRegs:0] vld_pipe;
  logic [NumPipeRegs:0] rdy;
  payload_t             dat_pipe [NumPipeRegs+1];

  assign vld_pipe[0]        = in_valid_i;
  assign dat_pipe[0]        = '{result: res_comb, tag: tag_i};
  assign rdy[NumPipeRegs]   = out_ready_i;

  for (genvar k = 0; k < NumPipeRegs; k++) begin : g_stage
    logic     vld_q;
    payload_t dat_q;

    // An empty stage always accepts, so bubbles collapse.
    assign rdy[k] = !vld_q | rdy[k+1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else if (rdy[k]) begin
        vld_q <= vld_pipe[k];
        if (vld_pipe[k]) dat_q <= dat_pipe[k];
      end
    end

    assign vld_pipe[k+1] = vld_q;
    assign dat_pipe[k+1] = dat_q;
  end

  assign in_ready_o  = rdy[0];
  assign out_valid_o = vld_pipe[NumPipeRegs];
  assign result_o    = dat_pipe[NumPipeRegs].result;
  assign tag_o       = dat_pipe[NumPipeRegs].tag;

  if (NumPipeRegs == 0) begin : g_busy0
    assign busy_o = 1'b0;
  end else begin : g_busy
    assign busy_o = |vld_pipe[NumPipeRegs:1];
  end
endmodule

// File: tb/tb_spatz_simd_lane_pipe.sv
module tb_spatz_simd_lane_pipe;
  import spatz_pkg::*;
  import rvv_pkg::*;

  localparam int W  = 32;
  localparam int NP = 2;
  localparam int TW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  op_e           operation_i;
  logic [W-1:0]  op_s1_i, op_s2_i, op_d_i;
  logic          is_signed_i;
  vew_e          sew_i;
  logic [TW-1:0] tag_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [W-1:0]  result_o;
  logic [TW-1:0] tag_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          busy_o;

  spatz_simd_lane_pipe #(.Width(W), .NumPipeRegs(NP), .TagWidth(TW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .operation_i (operation_i),
    .op_s1_i     (op_s1_i),
    .op_s2_i     (op_s2_i),
    .op_d_i      (op_d_i),
    .is_signed_i (is_signed_i),
    .sew_i       (sew_i),
    .tag_i       (tag_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .result_o    (result_o),
    .tag_o       (tag_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [W-1:0]  result;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb_q [$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_out = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Scoreboard: each output handshake pops the oldest expected entry.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      vectors++;
      assert (sb_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_out: observed tag %h result %h expected no output", tag_o, result_o);
      end
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        n_out++;
        check("sb_tag", 64'(tag_o), 64'(e.tag));
        check("sb_result", 64'(result_o), 64'(e.result));
      end
    end
  end

  task automatic drive(input op_e op, input vew_e sew, input logic sgn, input logic [W-1:0] s1,
                       input logic [W-1:0] s2, input logic [W-1:0] d, input logic [TW-1:0] tag);
    operation_i = op; sew_i = sew; is_signed_i = sgn;
    op_s1_i = s1; op_s2_i = s2; op_d_i = d; tag_i = tag;
    in_valid_i = 1'b1;
  endtask

  // Holds the request until it is accepted. Returns 1 time unit after the accepting edge.
  task automatic send(input op_e op, input vew_e sew, input logic sgn, input logic [W-1:0] s1,
                      input logic [W-1:0] s2, input logic [W-1:0] d, input logic [TW-1:0] tag,
                      input logic [W-1:0] exp);
    bit done = 0;
    drive(op, sew, sgn, s1, s2, d, tag);
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        sb_q.push_back('{result: exp, tag: tag});
        done = 1;
      end
      @(posedge clk_i); #1;
    end
    if (!done) check("accept_timeout", 64'(in_ready_o), 64'd1);
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
  endtask

  initial begin
    int base;
    rst_ni = 1'b0; out_ready_i = 1'b1; in_valid_i = 1'b0;
    operation_i = VADD; sew_i = EW_8; is_signed_i = 1'b0;
    op_s1_i = '0; op_s2_i = '0; op_d_i = '0; tag_i = '0;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_tag", 64'(tag_o), 64'd0);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("rst_in_ready", 64'(in_ready_o), 64'd1);

    // Test 1: VADD EW_8 plus latency and valid-pulse width
    send(VADD, EW_8, 1'b0, 32'h01FF7F80, 32'h01010101, '0, 4'h1, 32'h02008081);
    idle();
    check("t1_valid_edgeN", 64'(out_valid_o), 64'd0);
    @(posedge clk_i); #1;
    check("t1_valid_edgeN1", 64'(out_valid_o), 64'd1);
    check("t1_result", 64'(result_o), 64'h02008081);
    @(posedge clk_i); #1;
    check("t1_valid_edgeN2", 64'(out_valid_o), 64'd0);

    // Tests 2-4 plus extras: back-to-back at full throughput
    base = n_out;
    send(VMULHSU, EW_32, 1'b1, 32'hFFFFFFFF, 32'h00000002, '0, 4'h2, 32'hFFFFFFFF);
    send(VMULHU,  EW_32, 1'b1, 32'hFFFFFFFF, 32'h00000002, '0, 4'h3, 32'h00000001);
    send(VMUL,    EW_32, 1'b1, 32'hFFFFFFFF, 32'h00000002, '0, 4'h4, 32'hFFFFFFFE);
    send(VMACC,   EW_32, 1'b0, 32'd3, 32'd4, 32'd10, 4'h5, 32'd22);
    send(VNMSAC,  EW_32, 1'b0, 32'd3, 32'd4, 32'd10, 4'h6, 32'hFFFFFFFE);
    send(VMADD,   EW_32, 1'b0, 32'd3, 32'd10, 32'd4, 4'h7, 32'd22);
    send(VSRA,    EW_8,  1'b0, 32'h80808080, 32'h09010203, '0, 4'h8, 32'hC0C0E0F0);
    send(VADD,    EW_64, 1'b0, 32'h12345678, 32'h11111111, '0, 4'h9, 32'h00000000);
    send(VMIN,    EW_16, 1'b1, 32'h80000005, 32'h00010005, '0, 4'hA, 32'h80000005);
    send(VMAX,    EW_16, 1'b0, 32'h80000004, 32'h00010005, '0, 4'hB, 32'h80000005);
    send(VXOR,    EW_16, 1'b0, 32'hF0F0AAAA, 32'h0FF05555, '0, 4'hC, 32'hFF00FFFF);
    send(VNOP,    EW_32, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, 4'hD, 32'h00000000);
    send(VSUB,    EW_8,  1'b0, 32'h01020304, 32'h00000010, '0, 4'hE, 32'hFFFEFD0C);
    idle();
    repeat (3) @(posedge clk_i); #1;
    check("b2b_count", 64'(n_out - base), 64'd13);

    // Test 5: backpressure
    out_ready_i = 1'b0;
    send(VADD, EW_32, 1'b0, 32'd1, 32'd100, '0, 4'h1, 32'd101);
    send(VADD, EW_32, 1'b0, 32'd2, 32'd100, '0, 4'h2, 32'd102);
    drive(VADD, EW_32, 1'b0, 32'd3, 32'd100, '0, 4'h3);
    repeat (3) begin
      @(negedge clk_i);
      check("bp_in_ready", 64'(in_ready_o), 64'd0);
      check("bp_hold_tag", 64'(tag_o), 64'd1);
      check("bp_hold_valid", 64'(out_valid_o), 64'd1);
      @(posedge clk_i); #1;
    end
    base = n_out;
    out_ready_i = 1'b1;
    send(VADD, EW_32, 1'b0, 32'd3, 32'd100, '0, 4'h3, 32'd103);
    idle();
    repeat (2) @(posedge clk_i); #1;
    check("bp_drain_consec", 64'(n_out - base), 64'd3);
    check("bp_sb_empty", 64'(sb_q.size()), 64'd0);

    // Test 6: reset with two entries in flight
    out_ready_i = 1'b0;
    send(VOR, EW_32, 1'b0, 32'h0000F000, 32'h0000000F, '0, 4'h5, 32'h0000F00F);
    send(VOR, EW_32, 1'b0, 32'h00F00000, 32'h0000000F, '0, 4'h6, 32'h00F0000F);
    idle();
    check("rst6_busy_before", 64'(busy_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst6_out_valid", 64'(out_valid_o), 64'd0);
    check("rst6_busy", 64'(busy_o), 64'd0);
    check("rst6_result", 64'(result_o), 64'd0);
    check("rst6_tag", 64'(tag_o), 64'd0);
    sb_q.delete();
    #3 rst_ni = 1'b1;
    out_ready_i = 1'b1;
    #1;
    check("rst6_in_ready", 64'(in_ready_o), 64'd1);
    repeat (4) @(posedge clk_i); #1;
    check("rst6_no_stale", 64'(busy_o), 64'd0);
    base = n_out;
    send(VAND, EW_32, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, '0, 4'h7, 32'h0F000F00);
    idle();
    repeat (2) @(posedge clk_i); #1;
    check("rst6_post_count", 64'(n_out - base), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spatz_simd_lane_pipe.md
Name: spatz_simd_lane_pipe

Overview:
Next-generation Spatz integer SIMD lane. Datapath is `Width` bits wide, packed into Width/SEW independent elements selected at runtime by `sew_i`. It has an elastic valid/ready pipeline of `NumPipeRegs` stages and a per-request tag that travels with the result. The VIPU instantiates it per lane, replacing the single-element combinational lane so multiply-accumulate paths can be registered.

Parameters:
Width, 64, datapath width in bits; power of two, at least 8.
NumPipeRegs, 2, register stages from accept to output; 0 to 4.
TagWidth, 4, width of the opaque tag carried with each request; at least 1.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
operation_i  in  spatz_pkg::op_e  operation
op_s1_i  in  Width  operand s1, packed elements
op_s2_i  in  Width  operand s2, packed elements
op_d_i  in  Width  destination or accumulator operand, packed elements
is_signed_i  in  1  signed interpretation for MIN/MAX/MUL family
sew_i  in  rvv_pkg::vew_e  element width
tag_i  in  TagWidth  request tag
in_valid_i  in  1  request valid
in_ready_o  out  1  lane can accept
result_o  out  Width  packed result
tag_o  out  TagWidth  tag of the result
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
busy_o  out  1  at least one stage holds a valid entry

Behaviour:
- Element count is Width/SEW. Element i of the result depends only on element i of s1, s2 and d. No cross-element carry.
- If SEW > Width, the result is all zero.
- Supported operations:
  - VADD: s2+s1. VSUB: s2-s1. VRSUB: s1-s2. All modulo 2^SEW.
  - VMACC: d+s1*s2. VNMSAC: d-s1*s2.
  - VMADD: s2+s1*d. VNMSUB: s2-s1*d.
  - VMUL: low SEW bits of the 2*SEW product.
  - VMULH: high SEW bits, both operands signed iff is_signed_i.
  - VMULHU: high SEW bits, unsigned.
  - VMULHSU: high SEW bits, s1 signed iff is_signed_i, s2 unsigned.
  - VMIN/VMINU/VMAX/VMAXU: compare is signed iff is_signed_i; on a tie, VMIN returns s1 and VMAX returns s2.
  - VAND/VOR/VXOR: bitwise.
  - VSLL/VSRL/VSRA: shift s1; the amount is the low log2(SEW) bits of the s2 element.
  - Any other operation: result is zero.
- Pipeline: NumPipeRegs stages, each EMPTY or FULL (a valid bit plus payload of result and tag).
  - Stage k ready = !valid_k | ready_{k+1}. The last stage's downstream ready is out_ready_i. in_ready_o = ready of stage 0.
  - Bubble-collapsing: an empty stage always accepts.
  - Transfer into stage k when the upstream is valid and stage k is ready.
  - Payload registers load only on transfer; otherwise they hold their value.
  - A stage that is FULL and not ready holds its contents stable: no loss, no duplication.
  - Arithmetic is combinational ahead of stage 0; synthesis retiming is permitted.
- Latency: with out_ready_i=1, a request accepted at edge N appears on out_valid_o/result_o/tag_o from edge N+NumPipeRegs-1 onward and is consumed at edge N+NumPipeRegs. Throughput is 1 per cycle.
- NumPipeRegs=0: fully combinational. out_valid_o=in_valid_i, in_ready_o=out_ready_i, result and tag pass through.
- Outputs are stable while out_valid_o=1 and out_ready_i=0 (AXI-style). in_valid_i must not be dropped before acceptance.
- Simultaneous drain and fill of a FULL last stage in the same cycle is allowed with no bubble.
- busy_o is the OR of all stage valid bits; it is 0 when NumPipeRegs=0.
- Reset (asynchronous, any time):
  - All valid bits clear, so out_valid_o=0 and busy_o=0.
  - result_o=0, tag_o=0.
  - Entries in flight are discarded.
  - in_ready_o=1 after release (when NumPipeRegs>0).

Test Plan:
1. Width=32, NumPipeRegs=2, VADD EW_8, s1=0x01FF7F80, s2=0x01010101, out_ready_i=1 -> result 0x02008081; out_valid_o is high one cycle after the accepting edge for exactly one cycle.
2. EW_32, VMULHSU, is_signed_i=1, s1=0xFFFFFFFF, s2=0x00000002 -> 0xFFFFFFFF. Same operands with VMULHU -> 0x00000001. VMUL -> 0xFFFFFFFE.
3. EW_32 accumulate:
   - VMACC, s1=3, s2=4, d=10 -> 22.
   - VNMSAC, same operands -> 0xFFFFFFFE.
   - VMADD, s1=3, d=4, s2=10 -> 22.
4. EW_8, VSRA, s1=0x80808080, s2=0x09010203 -> 0xC0C0E0F0 (shift amount 9 masked to 1). EW_64 on Width=32 -> 0.
5. Backpressure: out_ready_i=0, issue tags 1,2,3 back-to-back -> in_ready_o drops after 2 accepts and tag 3 is held at the input. Raise out_ready_i -> tags 1,2,3 emerge in order on consecutive cycles with correct results.
6. Two entries in flight, pulse rst_ni low mid-cycle -> out_valid_o=0 and busy_o=0 immediately, result_o=0. After release no stale result ever emerges.
